// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq: walks a register ROM and issues one SCCB write per entry,
// honouring 16'hFFF0 delay markers and a 16'hFFFF end marker.
module ov7670_config_seq #(
   parameter logic [31:0] DELAY_CYCLES = 32'd1_000_000,
   parameter int          ROM_AW       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   output logic [ROM_AW-1:0] o_rom_addr,
   output logic              o_rom_en,
   input  logic [15:0]       i_rom_data,
   output logic              o_sccb_start,
   output logic [7:0]        o_sccb_reg,
   output logic [7:0]        o_sccb_val,
   input  logic              i_sccb_ready,
   output logic              o_busy,
   output logic              o_done
);
   typedef enum logic [3:0] {
      IDLE, FETCH, WAIT_ROM, DECODE, SEND, GUARD, WAIT_DONE, DELAY, DONE
   } state_t;

   state_t            r_state, w_next;
   logic [ROM_AW-1:0] r_addr;
   logic [7:0]        r_reg, r_val;
   logic [31:0]       r_cnt;
   logic              w_accept, w_adv, w_end, w_dly;

   assign w_end    = i_rom_data == 16'hFFFF;
   assign w_dly    = i_rom_data == 16'hFFF0;
   assign w_accept = (r_state == IDLE || r_state == DONE) && i_start;

   always_comb begin
      w_next = r_state;
      w_adv  = 1'b0;
      case (r_state)
         IDLE, DONE: if (i_start) w_next = FETCH;
         FETCH:      w_next = WAIT_ROM;
         WAIT_ROM:   w_next = DECODE;
         DECODE:     w_next = w_end ? DONE : w_dly ? DELAY : SEND;
         SEND:       if (i_sccb_ready) w_next = GUARD;
         GUARD:      w_next = WAIT_DONE;
         WAIT_DONE:  w_adv = i_sccb_ready;
         DELAY:      w_adv = r_cnt == DELAY_CYCLES - 32'd1;
         default:    w_next = IDLE;
      endcase
      // the last ROM address ends the sequence instead of wrapping to 0
      if (w_adv) w_next = &r_addr ? DONE : FETCH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_reg  <= '0;
         r_val  <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_accept) r_addr <= '0;
         else if (w_adv && !(&r_addr)) r_addr <= r_addr + 1'b1;
         if (r_state == DECODE && !w_end && !w_dly) begin
            r_reg <= i_rom_data[15:8];
            r_val <= i_rom_data[7:0];
         end
         if (r_state == DECODE) r_cnt <= '0;
         else if (r_state == DELAY) r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_rom_addr   = r_addr;
   assign o_rom_en     = r_state == FETCH;
   assign o_sccb_start = r_state == SEND && i_sccb_ready;
   assign o_sccb_reg   = r_reg;
   assign o_sccb_val   = r_val;
   assign o_busy       = r_state != IDLE && r_state != DONE;
   assign o_done       = r_state == DONE;
endmodule

// File: doc/ov7670_config_seq.md
OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

Interface
REQ-001 Parameter: DELAY_CYCLES, default 1_000_000; number of clk cycles spent on a delay entry.
REQ-002 Parameter: ROM_AW, default 8; ROM address width.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle request to run the configuration sequence.
REQ-006 rom_addr  out  ROM_AW  configuration ROM address.
REQ-007 rom_en  out  1  ROM clock enable; ROM registers rom_data on the next rising edge while high.
REQ-008 rom_data  in  16  ROM word {reg[15:8], val[7:0]}; 16'hFFFF = end, 16'hFFF0 = delay.
REQ-009 sccb_start  out  1  one-cycle write request to the SCCB master.
REQ-010 sccb_reg  out  8  register address, stable from sccb_start until the write completes.
REQ-011 sccb_val  out  8  register value, stable with sccb_reg.
REQ-012 sccb_ready  in  1  SCCB master idle; drops no later than 1 cycle after sccb_start.
REQ-013 busy  out  1  high in every state except IDLE and DONE.
REQ-014 done  out  1  high in DONE; held until the next accepted start.

Function
REQ-015 States: IDLE, FETCH, WAIT_ROM, DECODE, SEND, GUARD, WAIT_DONE, DELAY, DONE.
REQ-016 IDLE or DONE with start=1 -> FETCH, rom_addr<=0, done<=0; start in any other state is ignored.
REQ-017 FETCH: rom_en=1 for exactly this cycle -> WAIT_ROM; rom_en=0 in all other states.
REQ-018 WAIT_ROM: ROM output registers -> DECODE; rom_data is sampled only in DECODE (2 cycles after FETCH).
REQ-019 DECODE with rom_data=16'hFFFF -> DONE.
REQ-020 DECODE with rom_data=16'hFFF0 -> DELAY, delay counter<=0.
REQ-021 DECODE otherwise: latch sccb_reg<=rom_data[15:8] and sccb_val<=rom_data[7:0] -> SEND.
REQ-022 SEND: wait for sccb_ready=1; in that cycle sccb_start=1 -> GUARD; sccb_start is never high outside this cycle.
REQ-023 GUARD: one cycle, sccb_ready ignored -> WAIT_DONE.
REQ-024 WAIT_DONE: sccb_ready=1 -> address advance (REQ-026).
REQ-025 DELAY: counter increments each cycle; at counter==DELAY_CYCLES-1 -> address advance; total DELAY_CYCLES cycles in DELAY.
REQ-026 Address advance: rom_addr==2^ROM_AW-1 -> DONE (no wrap); otherwise rom_addr<=rom_addr+1 -> FETCH.
REQ-027 Delay counter is 32 bits wide; DELAY_CYCLES is limited to 1..2^32-1.
REQ-028 sccb_reg and sccb_val are updated only in DECODE for a non-marker word.
REQ-029 Entry 16'h0000 (ROM reset value) is a normal write of reg 0x00, value 0x00.
REQ-030 No timeout: the block waits indefinitely in SEND or WAIT_DONE while sccb_ready stays 0.

Reset
REQ-031 When rst_n=0, the block immediately enters IDLE: rom_addr=0, rom_en=0, sccb_start=0, sccb_reg=0, sccb_val=0, busy=0, done=0, delay counter=0.
REQ-032 Reset mid-operation (including mid-DELAY or WAIT_DONE) aborts the sequence with no further sccb_start; a new start is needed after release.
REQ-033 The first start is accepted on the first rising edge with rst_n=1.

Verification
REQ-034 ROM {0:1280, 1:FFF0, 2:FFFF}, DELAY_CYCLES=16, sccb_ready=1 -> start. Required: one sccb_start with reg=0x12 and val=0x80; 16 cycles in DELAY; done=1; rom_addr=2; exactly one write.
REQ-035 ROM {0:3A14, 1:FFFF}, sccb_ready held 0 for 50 cycles after start -> sccb_start fires only on the first cycle ready=1; master then holds ready low 20 cycles -> FETCH of addr 1 only after ready returns high.
REQ-036 All entries 0x0101 (no end marker), ROM_AW=3 -> 8 writes at addresses 0..7, then DONE with rom_addr=7; no wrap to 0.
REQ-037 start pulsed during WAIT_DONE and again in DONE -> first ignored; second restarts from addr 0 and clears done for one full sequence.
REQ-038 rst_n asserted in DELAY at counter=5 -> all outputs at reset values in the same cycle; after release, no activity until start.
REQ-039 Timing check on a plain write: rom_en is high one cycle at FETCH; sccb_start is asserted exactly 3 cycles after rom_en when sccb_ready=1 (FETCH, WAIT_ROM, DECODE, SEND).
